frame_ctrl: RTL
===============

Name: frame_ctrl

Overview:
Call-frame controller that initiates stack operations against SuperStack and consumes its status.
- Accepts CALL/RETURN commands from the interpreter core and keeps an internal LIFO of frame records {caller_base, return_pc}.
- Drives the SuperStack op/data/offset/underflow_limit/upper_limit inputs so each function sees only its own frame.
- Returns the saved return_pc or a trap code through a valid/ready response channel.

Parameters:
WIDTH, 8, stack data width; also the width of return_pc.
DEPTH, 3, SuperStack depth exponent; index/limit/offset width is DEPTH+1.
FRAMES_LOG2, 2, frame-record LIFO holds 1<<FRAMES_LOG2 entries.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller accepts command (IDLE only)
cmd_ret  in  1  0=CALL, 1=RETURN
cmd_count  in  DEPTH+1  CALL: number of args; RETURN: number of results (0 or 1)
cmd_pc  in  WIDTH  CALL: return_pc to save
resp_valid  out  1  response present
resp_ready  in  1  response consumed
resp_trap  out  3  0=ok, else trap code
resp_pc  out  WIDTH  RETURN: restored return_pc; CALL: 0
stack_op  out  3  SuperStack op
stack_data  out  WIDTH  SuperStack data
stack_offset  out  DEPTH+1  SuperStack offset
stack_underflow_limit  out  DEPTH+1  current frame base
stack_upper_limit  out  DEPTH+1  always equal to stack_underflow_limit
stack_index  in  DEPTH+1  SuperStack index
stack_out  in  WIDTH  SuperStack top of stack
stack_status  in  3  SuperStack status (registered; valid one cycle after an op)

Behaviour:
- Reset (async, reset=0):
  - state IDLE, base=0, frame count=0.
  - stack_op=NONE, stack_data=0, stack_offset=0, both limits 0.
  - cmd_ready=1, resp_valid=0, resp_trap=0, resp_pc=0.
- Reset mid-sequence aborts any in-flight command and discards all frame records.
- stack_op is NONE in every state except RET_ISSUE.
- Trap codes: 0 OK, 1 CALL_DEPTH (record LIFO full), 2 BAD_ARGS (cmd_count > index-base), 3 RET_EMPTY (no frame), 4 NO_RESULT (result requested, index==base), 5 BAD_COUNT (RETURN count>1), 6 STACK (status UNDERFLOW/OVERFLOW/BAD_OFFSET after issue).
- IDLE -> CHECK on cmd_valid&cmd_ready. Inputs are latched; cmd_ready drops.
- CHECK (1 cycle): evaluate traps in priority order 1,2 for CALL and 3,5,4 for RETURN. Any trap -> RESP with state unchanged. Otherwise CALL -> CALL_COMMIT, RETURN -> RET_ISSUE.
- CALL_COMMIT (1 cycle):
  - push {base, cmd_pc}.
  - base := stack_index - cmd_count (width DEPTH+1, no wrap since checked).
  - -> RESP with trap 0.
- RET_ISSUE (1 cycle):
  - pop record {cb, pc}.
  - stack_underflow_limit := cb in the same cycle as the op.
  - stack_offset := callee base.
  - count=1: stack_op=INDEX_RESET_AND_PUSH, stack_data=stack_out (combinational top, captured this cycle).
  - count=0: stack_op=INDEX_RESET.
  - base := cb. -> RET_CHECK.
- RET_CHECK (1 cycle): sample stack_status. UNDERFLOW/OVERFLOW/BAD_OFFSET -> trap 6 with the frame still popped; else trap 0, resp_pc=pc. -> RESP.
- RESP: resp_valid=1 and held stable until resp_ready. The cycle after the handshake returns to IDLE.
- Latency cmd accept -> resp_valid: CALL 2 cycles, RETURN 3 cycles, trap 1 cycle.
- New cmd is never accepted while a response is pending.
- Frame LIFO: a CALL at count==1<<FRAMES_LOG2 traps. Count never wraps.

Optional Feature:
FRAME_STATS_EN:
- Defined: adds output max_frames [FRAMES_LOG2:0], a high-water mark of frame count. Reset to 0; updates in the cycle after CALL_COMMIT.
- Undefined: port absent; no extra logic.

Decomposition:
- SuperStack.vh already carries the op and status encodings; the trap-code constants are added there.
- Sub-module frame_lifo: synchronous push/pop record store with full/empty flags and async active-low reset.

Test Plan:
1. Reset, push 3 values (1,2,3) directly, CALL count=2 pc=0x40 -> resp trap 0 after 2 cycles; stack_underflow_limit=1.
2. Then push 0x77, RETURN count=1 -> INDEX_RESET_AND_PUSH offset=1 data=0x77; resp_pc=0x40; then index=2, out=0x77, underflow_limit=0.
3. CALL count=5 with index=2 -> trap 2 after 1 cycle; limits unchanged.
4. Five CALLs count=0 -> fifth returns trap 1; four RETURN count=0 succeed; the next RETURN gives trap 3.
5. CALL count=0, then immediately RETURN count=1 -> trap 4; RETURN count=2 -> trap 5.
6. Hold resp_ready=0 for 4 cycles -> resp_valid/resp_pc stable, cmd_ready=0; assert reset mid-RET_ISSUE -> all outputs at reset values.

Source files
------------

// File: rtl/frame_ctrl_pkg.sv
// Shared encodings for the call-frame controller: SuperStack op/status
// codes, trap codes returned to the interpreter core, and FSM states.
package frame_ctrl_pkg;

    // SuperStack operation encodings driven on stack_op
    localparam logic [2:0] OP_NONE                 = 3'd0;
    localparam logic [2:0] OP_INDEX_RESET          = 3'd3;
    localparam logic [2:0] OP_INDEX_RESET_AND_PUSH = 3'd4;

    // SuperStack status encodings sampled from stack_status
    localparam logic [2:0] ST_OK         = 3'd0;
    localparam logic [2:0] ST_UNDERFLOW  = 3'd1;
    localparam logic [2:0] ST_OVERFLOW   = 3'd2;
    localparam logic [2:0] ST_BAD_OFFSET = 3'd3;

    // Trap codes reported on resp_trap
    localparam logic [2:0] TRAP_OK         = 3'd0;
    localparam logic [2:0] TRAP_CALL_DEPTH = 3'd1;
    localparam logic [2:0] TRAP_BAD_ARGS   = 3'd2;
    localparam logic [2:0] TRAP_RET_EMPTY  = 3'd3;
    localparam logic [2:0] TRAP_NO_RESULT  = 3'd4;
    localparam logic [2:0] TRAP_BAD_COUNT  = 3'd5;
    localparam logic [2:0] TRAP_STACK      = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_CALL_COMMIT,
        S_RET_ISSUE,
        S_RET_CHECK,
        S_RESP
    } state_t;

    // Statuses that mean the frame restore on RETURN went wrong
    function automatic logic is_stack_fault(input logic [2:0] st);
        return (st == ST_UNDERFLOW) || (st == ST_OVERFLOW) || (st == ST_BAD_OFFSET);
    endfunction

endpackage

// File: rtl/frame_lifo.sv
// Frame-record LIFO: synchronous push/pop store of {caller_base, return_pc}
// with full/empty flags. The top record is readable combinationally so the
// controller can use it in the same cycle it pops.
// Optional: FRAME_STATS_EN exposes the current record count.
module frame_lifo #(
    parameter int REC_W       = 12,
    parameter int FRAMES_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [REC_W-1:0] push_data,
    output logic [REC_W-1:0] top_data,
    output logic             full,
    output logic             empty
`ifdef FRAME_STATS_EN
    ,
    output logic [FRAMES_LOG2:0] count
`endif
);

    localparam int FRAMES = 1 << FRAMES_LOG2;

    logic [REC_W-1:0]       mem [FRAMES];
    logic [FRAMES_LOG2:0]   count_reg;
    logic [FRAMES_LOG2:0]   count_next;
    logic [FRAMES_LOG2-1:0] wr_ptr;
    logic [FRAMES_LOG2-1:0] top_ptr;
    logic                   do_push;
    logic                   do_pop;

    assign full     = (count_reg == (FRAMES_LOG2+1)'(FRAMES));
    assign empty    = (count_reg == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign wr_ptr   = count_reg[FRAMES_LOG2-1:0];
    assign top_ptr  = wr_ptr - 1'b1;
    assign top_data = mem[top_ptr];

`ifdef FRAME_STATS_EN
    assign count = count_reg;
`endif

    // Next record count; push and pop are never requested together
    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + 1'b1;
        end else if (do_pop && !do_push) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Record count register; reset discards every stored frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Record storage; contents are don't-care beyond the count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/frame_ctrl.sv
// Call-frame controller: accepts CALL/RETURN from the interpreter core,
// keeps a LIFO of {caller_base, return_pc} records and drives SuperStack
// so that each function only sees its own frame.
// Optional: FRAME_STATS_EN adds max_frames, a high-water mark of frame count.
module frame_ctrl
    import frame_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 3,
    parameter int FRAMES_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_ret,
    input  logic [DEPTH:0]   cmd_count,
    input  logic [WIDTH-1:0] cmd_pc,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [2:0]       resp_trap,
    output logic [WIDTH-1:0] resp_pc,
    output logic [2:0]       stack_op,
    output logic [WIDTH-1:0] stack_data,
    output logic [DEPTH:0]   stack_offset,
    output logic [DEPTH:0]   stack_underflow_limit,
    output logic [DEPTH:0]   stack_upper_limit,
    input  logic [DEPTH:0]   stack_index,
    input  logic [WIDTH-1:0] stack_out,
    input  logic [2:0]       stack_status
`ifdef FRAME_STATS_EN
    ,
    output logic [FRAMES_LOG2:0] max_frames
`endif
);

    localparam int LW    = DEPTH + 1;
    localparam int REC_W = LW + WIDTH;

    state_t           state_reg, state_next;
    logic [LW-1:0]    base_reg, base_next;
    logic             ret_reg;
    logic [LW-1:0]    count_reg;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] saved_pc_reg, saved_pc_next;
    logic [2:0]       resp_trap_reg, resp_trap_next;
    logic [WIDTH-1:0] resp_pc_reg, resp_pc_next;

    logic             lifo_push;
    logic             lifo_pop;
    logic [REC_W-1:0] lifo_top;
    logic             lifo_full;
    logic             lifo_empty;
    logic [LW-1:0]    top_cb;
    logic [WIDTH-1:0] top_pc;
    logic             args_short;

    assign top_cb = lifo_top[REC_W-1:WIDTH];
    assign top_pc = lifo_top[WIDTH-1:0];

    // Widened so base + count cannot wrap when compared against the index
    assign args_short = ({1'b0, count_reg} + {1'b0, base_reg}) > {1'b0, stack_index};

    assign resp_trap         = resp_trap_reg;
    assign resp_pc           = resp_pc_reg;
    assign stack_upper_limit = stack_underflow_limit;

`ifdef FRAME_STATS_EN
    logic [FRAMES_LOG2:0] lifo_count;
`endif

    frame_lifo #(
        .REC_W       (REC_W),
        .FRAMES_LOG2 (FRAMES_LOG2)
    ) u_lifo (
        .clk       (clk),
        .reset     (reset),
        .push      (lifo_push),
        .pop       (lifo_pop),
        .push_data ({base_reg, pc_reg}),
        .top_data  (lifo_top),
        .full      (lifo_full),
        .empty     (lifo_empty)
`ifdef FRAME_STATS_EN
        ,
        .count     (lifo_count)
`endif
    );

    // Next-state and output decode; stack_op is only active in RET_ISSUE
    always_comb begin
        state_next            = state_reg;
        base_next             = base_reg;
        saved_pc_next         = saved_pc_reg;
        resp_trap_next        = resp_trap_reg;
        resp_pc_next          = resp_pc_reg;
        lifo_push             = 1'b0;
        lifo_pop              = 1'b0;
        cmd_ready             = 1'b0;
        resp_valid            = 1'b0;
        stack_op              = OP_NONE;
        stack_data            = '0;
        stack_offset          = '0;
        stack_underflow_limit = base_reg;

        case (state_reg)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                resp_pc_next = '0;
                if (!ret_reg) begin
                    if (lifo_full) begin
                        resp_trap_next = TRAP_CALL_DEPTH;
                        state_next     = S_RESP;
                    end else if (args_short) begin
                        resp_trap_next = TRAP_BAD_ARGS;
                        state_next     = S_RESP;
                    end else begin
                        state_next = S_CALL_COMMIT;
                    end
                end else begin
                    if (lifo_empty) begin
                        resp_trap_next = TRAP_RET_EMPTY;
                        state_next     = S_RESP;
                    end else if (count_reg > LW'(1)) begin
                        resp_trap_next = TRAP_BAD_COUNT;
                        state_next     = S_RESP;
                    end else if ((count_reg == LW'(1)) && (stack_index == base_reg)) begin
                        resp_trap_next = TRAP_NO_RESULT;
                        state_next     = S_RESP;
                    end else begin
                        state_next = S_RET_ISSUE;
                    end
                end
            end
            S_CALL_COMMIT: begin
                lifo_push      = 1'b1;
                base_next      = stack_index - count_reg;
                resp_trap_next = TRAP_OK;
                resp_pc_next   = '0;
                state_next     = S_RESP;
            end
            S_RET_ISSUE: begin
                lifo_pop              = 1'b1;
                stack_underflow_limit = top_cb;
                stack_offset          = base_reg;
                if (count_reg == LW'(1)) begin
                    stack_op   = OP_INDEX_RESET_AND_PUSH;
                    stack_data = stack_out;
                end else begin
                    stack_op = OP_INDEX_RESET;
                end
                base_next     = top_cb;
                saved_pc_next = top_pc;
                state_next    = S_RET_CHECK;
            end
            S_RET_CHECK: begin
                if (is_stack_fault(stack_status)) begin
                    resp_trap_next = TRAP_STACK;
                    resp_pc_next   = '0;
                end else begin
                    resp_trap_next = TRAP_OK;
                    resp_pc_next   = saved_pc_reg;
                end
                state_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // FSM, frame base and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            base_reg      <= '0;
            saved_pc_reg  <= '0;
            resp_trap_reg <= TRAP_OK;
            resp_pc_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            base_reg      <= base_next;
            saved_pc_reg  <= saved_pc_next;
            resp_trap_reg <= resp_trap_next;
            resp_pc_reg   <= resp_pc_next;
        end
    end

    // Latch the command on acceptance so the core may change its inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ret_reg   <= 1'b0;
            count_reg <= '0;
            pc_reg    <= '0;
        end else if ((state_reg == S_IDLE) && cmd_valid) begin
            ret_reg   <= cmd_ret;
            count_reg <= cmd_count;
            pc_reg    <= cmd_pc;
        end
    end

`ifdef FRAME_STATS_EN
    // High-water mark follows the record count one cycle after a commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_frames <= '0;
        end else if (lifo_count > max_frames) begin
            max_frames <= lifo_count;
        end
    end
`endif

endmodule
